// File: rtl/image_rom_streamer.sv
// Streams one IMG_W x IMG_H frame from a 1-cycle-latency ROM as a valid/ready pixel stream in
// raster order, optionally mirroring each row; a 2-entry output FIFO absorbs consumer stalls.
module image_rom_streamer #(
  parameter int unsigned IMG_W  = 96,
  parameter int unsigned IMG_H  = 64,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 16
) (
  input  logic              CLOCK,
  input  logic              RESETN,
  input  logic              start,
  input  logic              mirror,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              busy,
  output logic              done
);

  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ColW-1:0]   ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0]   RowLast = RowW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] WAddr   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] WLast   = ADDR_W'(IMG_W - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e            state_q;
  logic [ColW-1:0]   col_q;
  logic [RowW-1:0]   row_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;
  logic              mirror_q;
  logic              busy_q, done_q;
  // Read presented last cycle: its data is on rom_data now and is pushed at this edge.
  logic              rd_q, rd_sof_q, rd_eol_q;

  logic [DATA_W-1:0] fifo_data_q [2];
  logic [1:0]        fifo_sof_q, fifo_eol_q;
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q;

  logic              pop, issue, last_rd;
  logic [1:0]        cnt_after_pop, count_d;
  logic [ColW-1:0]   col_n;
  logic [RowW-1:0]   row_n;
  logic [ADDR_W-1:0] base_n, addr_n;

  assign rom_addr  = addr_q;
  assign pix_valid = (count_q != 2'd0);
  assign pix_data  = fifo_data_q[rd_ptr_q];
  assign pix_sof   = pix_valid & fifo_sof_q[rd_ptr_q];
  assign pix_eol   = pix_valid & fifo_eol_q[rd_ptr_q];
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    pop           = pix_valid & pix_ready;
    cnt_after_pop = count_q - {1'b0, pop};
    count_d       = cnt_after_pop + {1'b0, rd_q};
    // Reserve a FIFO slot for every outstanding read so returning data is never dropped.
    issue   = (state_q == StFetch) &&
              (({1'b0, cnt_after_pop} + {2'b0, rd_q} + 3'd1) <= 3'd2);
    last_rd = (row_q == RowLast) && (col_q == ColLast);
    if (col_q == ColLast) begin
      col_n  = '0;
      row_n  = row_q + RowW'(1);
      base_n = base_q + WAddr;
    end else begin
      col_n  = col_q + ColW'(1);
      row_n  = row_q;
      base_n = base_q;
    end
    addr_n = base_n + (mirror_q ? (WLast - ADDR_W'(col_n)) : ADDR_W'(col_n));
  end

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      state_q        <= StIdle;
      col_q          <= '0;
      row_q          <= '0;
      base_q         <= '0;
      addr_q         <= '0;
      mirror_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      rd_q           <= 1'b0;
      rd_sof_q       <= 1'b0;
      rd_eol_q       <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_sof_q     <= '0;
      fifo_eol_q     <= '0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= '0;
    end else begin
      done_q  <= 1'b0;
      rd_q    <= issue;
      count_q <= count_d;
      if (issue) begin
        rd_sof_q <= (row_q == '0) && (col_q == '0);
        rd_eol_q <= (col_q == ColLast);
      end
      if (rd_q) begin
        fifo_data_q[wr_ptr_q] <= rom_data;
        fifo_sof_q[wr_ptr_q]  <= rd_sof_q;
        fifo_eol_q[wr_ptr_q]  <= rd_eol_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StFetch;
            col_q    <= '0;
            row_q    <= '0;
            base_q   <= '0;
            mirror_q <= mirror;
            addr_q   <= mirror ? WLast : '0;
            busy_q   <= 1'b1;
          end
        end
        StFetch: begin
          if (issue) begin
            if (last_rd) begin
              state_q <= StDrain;
            end else begin
              col_q  <= col_n;
              row_q  <= row_n;
              base_q <= base_n;
              addr_q <= addr_n;
            end
          end
        end
        StDrain: begin
          if (count_d == 2'd0) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
